elevator_drive_ctrl: RTL and testbench

Car drive controller: consumer end of the request-queue interface. Takes the head-of-queue destination (`des`) and `go` from the queue, moves the car one floor per 2 s tick toward it, and publishes the updated floor (`newState`) back to the queue. Also drives the 4-phase stepper-motor coil outputs and the door/arrival indications. Sits between the queue and the motor/segment-display pins.

---
 rtl/elevator_pkg.sv | 24 ++
 rtl/stepper_seq.sv | 74 +++++++
 rtl/elevator_drive_ctrl.sv | 121 ++++++++++++
 tb/tb_elevator_drive_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// Shared types and constants for the elevator car drive controller.
// Floors are one-hot: bit 0 is the bottom floor, bit 3 the top floor.
package elevator_pkg;

    typedef logic [3:0] floor_t;

    localparam floor_t FLOOR1 = 4'b0001;
    localparam floor_t FLOOR2 = 4'b0010;
    localparam floor_t FLOOR3 = 4'b0100;
    localparam floor_t FLOOR4 = 4'b1000;
    localparam floor_t NO_REQ = 4'b1111;

    typedef enum logic [1:0] {
        StIdle,
        StMoveUp,
        StMoveDown,
        StDwell
    } drive_state_e;

    function automatic logic is_onehot4(input floor_t v);
        return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
    endfunction

endpackage

// File: rtl/stepper_seq.sv
// Stepper coil phase ring: advances one phase every step period while run is high.
// Build option DRIVE_HALFSTEP_EN selects the 8-step half-step ring at half the period.
module stepper_seq #(
    parameter int unsigned STEP_DIV = 25000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic       up,
    output logic [3:0] motor
);

`ifdef DRIVE_HALFSTEP_EN
    localparam int unsigned PhaseW = 3;
    localparam int unsigned Period = (STEP_DIV / 2 > 0) ? STEP_DIV / 2 : 1;
`else
    localparam int unsigned PhaseW = 2;
    localparam int unsigned Period = (STEP_DIV > 0) ? STEP_DIV : 1;
`endif
    localparam int unsigned CntW = (Period > 1) ? $clog2(Period) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(Period - 1);

    logic [PhaseW-1:0] phase_q, phase_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [3:0]        ring;

    always_comb begin
        phase_d = phase_q;
        cnt_d   = cnt_q;
        // Holding at phase 0 while stopped makes every move start at 0001.
        if (!run) begin
            phase_d = '0;
            cnt_d   = '0;
        end else if (cnt_q == CntLast) begin
            cnt_d   = '0;
            phase_d = up ? phase_q + PhaseW'(1) : phase_q - PhaseW'(1);
        end else begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase_q <= '0;
            cnt_q   <= '0;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef DRIVE_HALFSTEP_EN
    always_comb begin
        ring = 4'b0001;
        case (phase_q)
            3'd0:    ring = 4'b0001;
            3'd1:    ring = 4'b0011;
            3'd2:    ring = 4'b0010;
            3'd3:    ring = 4'b0110;
            3'd4:    ring = 4'b0100;
            3'd5:    ring = 4'b1100;
            3'd6:    ring = 4'b1000;
            default: ring = 4'b1001;
        endcase
    end
`else
    always_comb begin
        ring = 4'b0001 << phase_q;
    end
`endif

    assign motor = run ? ring : 4'b0000;

endmodule

// File: rtl/elevator_drive_ctrl.sv
// Car drive controller: moves the car one floor per tick toward the queue head and dwells on stop.
// Optional build macro DRIVE_HALFSTEP_EN (in stepper_seq) selects half-step coil drive.
module elevator_drive_ctrl
    import elevator_pkg::*;
#(
    parameter int unsigned STEP_DIV    = 25000,
    parameter int unsigned DWELL_TICKS = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       go,
    input  logic [3:0] des,
    output logic [3:0] newState,
    output logic [3:0] motor,
    output logic       dir_up,
    output logic       moving,
    output logic       door_open,
    output logic       arrived
);

    localparam logic [3:0] DwellLast = 4'(DWELL_TICKS - 1);

    drive_state_e state_q, state_d;
    floor_t       floor_q, floor_d;
    logic [3:0]   dwell_q, dwell_d;
    logic         arrived_q, arrived_d;

    logic         des_valid;
    logic         at_end;
    floor_t       step_floor;

    always_comb begin
        state_d    = state_q;
        floor_d    = floor_q;
        dwell_d    = dwell_q;
        arrived_d  = 1'b0;
        des_valid  = is_onehot4(des);
        at_end     = (state_q == StMoveUp) ? (floor_q == FLOOR4) : (floor_q == FLOOR1);
        step_floor = (state_q == StMoveUp) ? (floor_q << 1) : (floor_q >> 1);

        unique case (state_q)
            StIdle: begin
                // One-hot codes order numerically by floor, so plain compares pick direction.
                if (go && des_valid) begin
                    if (des > floor_q) begin
                        state_d = StMoveUp;
                    end else if (des < floor_q) begin
                        state_d = StMoveDown;
                    end
                end
            end
            StMoveUp, StMoveDown: begin
                if (tick) begin
                    if (at_end) begin
                        state_d = StDwell;
                        dwell_d = '0;
                    end else begin
                        floor_d = step_floor;
                        if (des_valid && (des == step_floor)) begin
                            state_d   = StDwell;
                            dwell_d   = '0;
                            arrived_d = 1'b1;
                        end else if (!des_valid) begin
                            state_d = StDwell;
                            dwell_d = '0;
                        end else if ((state_q == StMoveUp) && (des < step_floor)) begin
                            state_d = StMoveDown;
                        end else if ((state_q == StMoveDown) && (des > step_floor)) begin
                            state_d = StMoveUp;
                        end
                    end
                end
            end
            StDwell: begin
                if (tick) begin
                    if (dwell_q == DwellLast) begin
                        state_d = StIdle;
                        dwell_d = '0;
                    end else begin
                        dwell_d = dwell_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            floor_q   <= FLOOR1;
            dwell_q   <= '0;
            arrived_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            floor_q   <= floor_d;
            dwell_q   <= dwell_d;
            arrived_q <= arrived_d;
        end
    end

    assign newState  = floor_q;
    assign moving    = (state_q == StMoveUp) || (state_q == StMoveDown);
    assign dir_up    = (state_q == StMoveUp);
    assign door_open = (state_q == StDwell);
    assign arrived   = arrived_q;

    stepper_seq #(
        .STEP_DIV(STEP_DIV)
    ) u_stepper_seq (
        .clk  (clk),
        .rst_n(rst_n),
        .run  (moving),
        .up   (dir_up),
        .motor(motor)
    );

endmodule

// File: tb/tb_elevator_drive_ctrl.sv
// Self-checking bench for elevator_drive_ctrl against a floor-number behavioural model.
module tb_elevator_drive_ctrl;

    localparam int unsigned STEP_DIV    = 8;
    localparam int unsigned DWELL_TICKS = 2;

    logic       clk;
    logic       rst_n;
    logic       tick;
    logic       go;
    logic [3:0] des;
    logic [3:0] newState;
    logic [3:0] motor;
    logic       dir_up;
    logic       moving;
    logic       door_open;
    logic       arrived;

    int vectors;
    int miscompares;

    // Model: floor 1..4, mode 0 idle / 1 travelling / 2 door open.
    int m_floor;
    int m_mode;
    int m_dir;
    int m_dwell_left;
    int m_phase;
    int m_cyc;
    bit m_arrived;

    elevator_drive_ctrl #(
        .STEP_DIV   (STEP_DIV),
        .DWELL_TICKS(DWELL_TICKS)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tick     (tick),
        .go       (go),
        .des      (des),
        .newState (newState),
        .motor    (motor),
        .dir_up   (dir_up),
        .moving   (moving),
        .door_open(door_open),
        .arrived  (arrived)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int des_floor(input logic [3:0] d);
        case (d)
            4'b0001: return 1;
            4'b0010: return 2;
            4'b0100: return 3;
            4'b1000: return 4;
            default: return 0;
        endcase
    endfunction

    function automatic logic [11:0] exp_vec();
        logic [3:0] ef;
        logic [3:0] em;
        ef = 4'b0001 << (m_floor - 1);
        em = (m_mode == 1) ? (4'b0001 << (((m_phase % 4) + 4) % 4)) : 4'b0000;
        return {ef, em, (m_mode == 1 && m_dir == 1), (m_mode == 1), (m_mode == 2), m_arrived};
    endfunction

    function automatic logic [11:0] dut_vec();
        return {newState, motor, dir_up, moving, door_open, arrived};
    endfunction

    task automatic model_step();
        int tgt;
        tgt = des_floor(des);
        if (!rst_n) begin
            m_floor = 1; m_mode = 0; m_dir = 1; m_dwell_left = 0;
            m_phase = 0; m_cyc = 0; m_arrived = 0;
            return;
        end
        m_arrived = 0;
        if (m_mode == 1) begin
            m_cyc++;
            if (m_cyc == STEP_DIV) begin
                m_cyc = 0;
                m_phase += m_dir;
            end
        end else begin
            m_cyc = 0;
            m_phase = 0;
        end
        if (m_mode == 0) begin
            if (go && tgt != 0 && tgt != m_floor) begin
                m_mode = 1;
                m_dir = (tgt > m_floor) ? 1 : -1;
            end
        end else if (m_mode == 1) begin
            if (tick) begin
                if ((m_dir == 1 && m_floor == 4) || (m_dir == -1 && m_floor == 1)) begin
                    m_mode = 2; m_dwell_left = DWELL_TICKS;
                end else begin
                    m_floor += m_dir;
                    if (tgt == m_floor) begin
                        m_mode = 2; m_dwell_left = DWELL_TICKS; m_arrived = 1;
                    end else if (tgt == 0) begin
                        m_mode = 2; m_dwell_left = DWELL_TICKS;
                    end else if ((tgt - m_floor) * m_dir < 0) begin
                        m_dir = -m_dir;
                    end
                end
            end
        end else if (tick) begin
            m_dwell_left--;
            if (m_dwell_left == 0) m_mode = 0;
        end
    endtask

    task automatic do_cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; tick = 1'b0; go = 1'b0; des = 4'b1111;
        for (int i = 0; i < 3; i++) do_cycle();
        vectors++;
        if (dut_vec() !== 12'b0001_0000_0000) begin
            miscompares++;
            $display("FAIL reset_state got=%h exp=%h", dut_vec(), 12'h100);
        end
        vectors++;
        if (dut_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL reset_model got=%h exp=%h", dut_vec(), exp_vec());
        end
        rst_n = 1'b1;
    endtask

    task automatic test_up_run();
        int arr_cnt = 0;
        go = 1'b1; des = 4'b1000;
        for (int i = 0; i < 700; i++) begin
            tick = (i % 100 == 99);
            do_cycle();
            vectors++;
            if (dut_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL up_run cyc=%0d got=%h exp=%h", i, dut_vec(), exp_vec());
            end
            if (arrived) arr_cnt++;
        end
        vectors++;
        if (arr_cnt !== 1 || newState !== 4'b1000) begin
            miscompares++;
            $display("FAIL up_arrive pulses=%0d floor=%b exp=1 1000", arr_cnt, newState);
        end
    endtask

    task automatic test_down_run();
        int arr_cnt = 0;
        go = 1'b1; des = 4'b0001;
        for (int i = 0; i < 700; i++) begin
            // A tick in the acceptance cycle must not move the car.
            tick = (i == 0) || (i % 100 == 99);
            do_cycle();
            vectors++;
            if (dut_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL down_run cyc=%0d got=%h exp=%h", i, dut_vec(), exp_vec());
            end
            if (arrived) arr_cnt++;
        end
        vectors++;
        if (arr_cnt !== 1 || newState !== 4'b0001) begin
            miscompares++;
            $display("FAIL down_arrive pulses=%0d floor=%b exp=1 0001", arr_cnt, newState);
        end
    endtask

    task automatic test_retarget();
        int arr_cnt = 0;
        go = 1'b1; des = 4'b1000;
        for (int i = 0; i < 900; i++) begin
            tick = (i % 100 == 99);
            if (i == 150) des = 4'b0001;
            do_cycle();
            vectors++;
            if (dut_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL retarget cyc=%0d got=%h exp=%h", i, dut_vec(), exp_vec());
            end
            if (arrived) arr_cnt++;
        end
        vectors++;
        if (arr_cnt !== 1 || newState !== 4'b0001) begin
            miscompares++;
            $display("FAIL retarget_end pulses=%0d floor=%b exp=1 0001", arr_cnt, newState);
        end
    endtask

    task automatic test_cancel();
        int arr_cnt = 0;
        go = 1'b1; des = 4'b1000;
        for (int i = 0; i < 600; i++) begin
            tick = (i % 100 == 99);
            if (i == 150) des = 4'b1111;
            do_cycle();
            vectors++;
            if (dut_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL cancel cyc=%0d got=%h exp=%h", i, dut_vec(), exp_vec());
            end
            if (arrived) arr_cnt++;
        end
        vectors++;
        if (arr_cnt !== 0 || newState !== 4'b0100 || door_open !== 1'b0) begin
            miscompares++;
            $display("FAIL cancel_end pulses=%0d floor=%b door=%b exp=0 0100 0",
                     arr_cnt, newState, door_open);
        end
    endtask

    task automatic test_no_move();
        int busy = 0;
        go = 1'b1;
        for (int i = 0; i < 400; i++) begin
            des = (i < 200) ? 4'b0101 : 4'b0100;
            tick = (i % 50 == 49);
            do_cycle();
            vectors++;
            if (dut_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL no_move cyc=%0d got=%h exp=%h", i, dut_vec(), exp_vec());
            end
            if (moving || arrived || motor != 4'b0000) busy++;
        end
        vectors++;
        if (busy !== 0) begin
            miscompares++;
            $display("FAIL no_move_idle busy_cycles=%0d exp=0", busy);
        end
    endtask

    task automatic test_reset_mid_move();
        go = 1'b1; des = 4'b1000; tick = 1'b0;
        for (int i = 0; i < 50; i++) do_cycle();
        vectors++;
        if (moving !== 1'b1 || newState !== 4'b0100) begin
            miscompares++;
            $display("FAIL pre_reset moving=%b floor=%b exp=1 0100", moving, newState);
        end
        rst_n = 1'b0;
        do_cycle();
        rst_n = 1'b1; go = 1'b0;
        vectors++;
        if (newState !== 4'b0001 || motor !== 4'b0000 || moving !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset floor=%b motor=%b moving=%b exp=0001 0000 0",
                     newState, motor, moving);
        end
    endtask

    task automatic test_random();
        logic [3:0] pick;
        for (int i = 0; i < 5000; i++) begin
            tick  = ($urandom_range(0, 24) == 0);
            rst_n = ($urandom_range(0, 2499) != 0);
            if ($urandom_range(0, 39) == 0) begin
                case ($urandom_range(0, 5))
                    0: pick = 4'b1111;
                    1: pick = 4'($urandom_range(0, 15));
                    default: pick = 4'b0001 << $urandom_range(0, 3);
                endcase
                des = pick;
                go  = ($urandom_range(0, 3) != 0);
            end
            do_cycle();
            vectors++;
            if (dut_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL random cyc=%0d des=%b got=%h exp=%h", i, des, dut_vec(), exp_vec());
            end
        end
        rst_n = 1'b1;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        m_floor = 1; m_mode = 0; m_dir = 1; m_dwell_left = 0;
        m_phase = 0; m_cyc = 0; m_arrived = 0;
        rst_n = 1'b0; tick = 1'b0; go = 1'b0; des = 4'b1111;
        test_reset();
        test_up_run();
        test_down_run();
        test_retarget();
        test_cancel();
        test_no_move();
        test_reset_mid_move();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
